// File: rtl/multi_button_if.sv
// Interface bundling the button inputs and the detector outputs.
// master: the side that owns the raw buttons and consumes the events.
// slave : the multi_button_detector itself.
interface multi_button_if #(
  parameter int N_BTN = 5
);

  logic [N_BTN-1:0] btn_in;      // raw asynchronous button levels, active-high
  logic [N_BTN-1:0] level;       // debounced button state
  logic [N_BTN-1:0] pressed;     // 1-cycle pulse on accepted press (and repeats)
  logic [N_BTN-1:0] released;    // 1-cycle pulse on accepted release
  logic [N_BTN-1:0] long_press;  // 1-cycle pulse when a hold reaches HOLD_TICKS

  modport master (
    output btn_in,
    input  level,
    input  pressed,
    input  released,
    input  long_press
  );

  modport slave (
    input  btn_in,
    output level,
    output pressed,
    output released,
    output long_press
  );

endinterface : multi_button_if

// File: rtl/multi_button_detector.sv
// multi_button_detector
//   N independent button channels, each with a 2-flop synchroniser,
//   tick-paced counter debounce, registered press/release pulses and a
//   long-press detector. Everything runs on clk; a shared tick enable
//   paces the debounce and hold counters.
//
//   Optional feature macro: MULTI_BUTTON_AUTOREPEAT_EN
//     When defined, a held button keeps generating pressed pulses every
//     REPEAT_TICKS ticks once long_press has fired.
module multi_button_detector #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 100000,
  parameter int DEB_SAMPLES  = 4,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 100
) (
  input  logic            clk,
  input  logic            rst,
  multi_button_if.slave   bus
);

  // Counter widths: each counter can hold its full terminal value.
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int DEB_W  = $clog2(DEB_SAMPLES + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_TICKS);

  // Elaboration-time guards on the legal parameter ranges.
  if (N_BTN < 1) begin : g_bad_n_btn
    $error("multi_button_detector: N_BTN must be >= 1");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("multi_button_detector: TICK_DIV must be >= 2");
  end
  if (DEB_SAMPLES < 1) begin : g_bad_deb_samples
    $error("multi_button_detector: DEB_SAMPLES must be >= 1");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold_ticks
    $error("multi_button_detector: HOLD_TICKS must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat_ticks
    $error("multi_button_detector: REPEAT_TICKS must be >= 1");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic [N_BTN-1:0]  sync_meta;
  logic [N_BTN-1:0]  sync_q;

  logic [N_BTN-1:0]  level_q;
  logic [N_BTN-1:0]  pressed_q;
  logic [N_BTN-1:0]  released_q;
  logic [N_BTN-1:0]  long_q;

  logic [DEB_W-1:0]  deb_cnt  [N_BTN];
  logic [HOLD_W-1:0] hold_cnt [N_BTN];

  // Per-channel decisions for the current cycle.
  logic [N_BTN-1:0]  deb_diff;    // synchronised input disagrees with level
  logic [N_BTN-1:0]  deb_accept;  // new level accepted on this tick
  logic [N_BTN-1:0]  hold_hit;    // hold counter reaches HOLD_TICKS on this tick
  logic [N_BTN-1:0]  hold_full;   // hold counter already saturated
  logic [N_BTN-1:0]  rep_fire;    // auto-repeat pressed pulse on this tick

  // ---------------------------------------------------------------------
  // Shared tick generator
  // ---------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sample-tick divider shared by all channels.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop
    // samples the pre-edge value of its sources, independent of ordering.
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  // Two-flop synchroniser bringing the raw buttons into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= bus.btn_in;
      sync_q    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel decision logic
  // ---------------------------------------------------------------------
  // Decode which channels accept a new level, hit the hold threshold or
  // fire a repeat on this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    deb_diff   = '0;
    deb_accept = '0;
    hold_hit   = '0;
    hold_full  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_diff[i]   = sync_q[i] ^ level_q[i];
      deb_accept[i] = tick & deb_diff[i] & (deb_cnt[i] == DEB_LAST);
      hold_full[i]  = (hold_cnt[i] == HOLD_SAT);
      hold_hit[i]   = tick & level_q[i] & (hold_cnt[i] == HOLD_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Debounce, level and edge pulses
  // ---------------------------------------------------------------------
  // Count consecutive disagreeing ticks; accept the new level on the last
  // one and emit the matching one-cycle edge pulse alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        pressed_q[i]  <= (deb_accept[i] & sync_q[i]) | rep_fire[i];
        released_q[i] <= deb_accept[i] & ~sync_q[i];
        if (tick) begin
          if (!deb_diff[i]) begin
            deb_cnt[i] <= '0;
          end else if (deb_accept[i]) begin
            level_q[i] <= sync_q[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Long-press detection
  // ---------------------------------------------------------------------
  // Count ticks of continuous debounced-high, saturating so long_press
  // fires only once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        long_q[i] <= hold_hit[i];
        if (!level_q[i]) begin
          hold_cnt[i] <= '0;
        end else if (tick && !hold_full[i]) begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
        end
      end
    end
  end

`ifdef MULTI_BUTTON_AUTOREPEAT_EN
  // ---------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------
  localparam int                REP_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] rep_cnt [N_BTN];

  // A repeat is due when the hold has saturated and the repeat counter
  // completes its period on this tick.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_fire[i] = tick & level_q[i] & hold_full[i] & (rep_cnt[i] == REP_LAST);
    end
  end

  // Repeat period counter, running only after long_press has fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!level_q[i]) begin
          rep_cnt[i] <= '0;
        end else if (tick && hold_full[i]) begin
          if (rep_cnt[i] == REP_LAST) begin
            rep_cnt[i] <= '0;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
          end
        end
      end
    end
  end
`else
  // Without auto-repeat, pressed comes only from debounced presses.
  assign rep_fire = '0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.level      = level_q;
  assign bus.pressed    = pressed_q;
  assign bus.released   = released_q;
  assign bus.long_press = long_q;

endmodule : multi_button_detector

// File: tb/tb_multi_button_detector.sv
// Directed self-checking bench for multi_button_detector.
// Small parameters keep every latency a handful of cycles:
//   N_BTN=2, TICK_DIV=4, DEB_SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2.
module tb_multi_button_detector;

  localparam int N_BTN        = 2;
  localparam int TICK_DIV     = 4;
  localparam int DEB_SAMPLES  = 3;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;

  localparam int SEL_PRESS   = 0;
  localparam int SEL_RELEASE = 1;
  localparam int SEL_LONG    = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_button_if #(.N_BTN(N_BTN)) bus ();

  multi_button_detector #(
    .N_BTN        (N_BTN),
    .TICK_DIV     (TICK_DIV),
    .DEB_SAMPLES  (DEB_SAMPLES),
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  int press_cnt [N_BTN];
  int rel_cnt   [N_BTN];
  int long_cnt  [N_BTN];

  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt = check_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N_BTN; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      long_cnt[i]  = 0;
    end
  endtask

  // Advance n clock edges; observe 1 time unit after each edge and tally pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_BTN; i++) begin
        press_cnt[i] += int'(bus.pressed[i]);
        rel_cnt[i]   += int'(bus.released[i]);
        long_cnt[i]  += int'(bus.long_press[i]);
      end
    end
  endtask

  function automatic logic pulse_of(input int sel, input int ch);
    case (sel)
      SEL_PRESS:   return bus.pressed[ch];
      SEL_RELEASE: return bus.released[ch];
      default:     return bus.long_press[ch];
    endcase
  endfunction

  // Step until the selected pulse is seen; cycles = edges taken, -1 on timeout.
  task automatic wait_pulse(input int sel, input int ch, input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      step(1);
      if (pulse_of(sel, ch)) begin
        cycles = c;
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.btn_in = '0;
    clear_counts();
    step(3);

    // Reset state
    check("reset_level",      32'(bus.level),      32'd0);
    check("reset_pressed",    32'(bus.pressed),    32'd0);
    check("reset_released",   32'(bus.released),   32'd0);
    check("reset_long_press", 32'(bus.long_press), 32'd0);
    rst = 1'b0;
    step(5);

    // Clean press on channel 0, held 40 cycles
    clear_counts();
    bus.btn_in = 2'b01;
    wait_pulse(SEL_PRESS, 0, 20, cyc);
    check("clean_press_latency_ok", 32'(cyc >= 11 && cyc <= 14), 32'd1);
    check("clean_press_level",      32'(bus.level),   32'b01);
    check("clean_press_pulse_bits", 32'(bus.pressed), 32'b01);
    step(1);
    check("clean_press_one_cycle",  32'(bus.pressed), 32'd0);
    step(40 - cyc - 1);
    check("clean_press_count",      32'(press_cnt[0]), 32'd1);
    check("clean_no_release",       32'(rel_cnt[0]),   32'd0);
    check("clean_ch1_idle",         32'(press_cnt[1] + rel_cnt[1] + long_cnt[1] + int'(bus.level[1])), 32'd0);
    bus.btn_in = 2'b00;
    wait_pulse(SEL_RELEASE, 0, 20, cyc);
    check("clean_release_seen",     32'(cyc > 0),   32'd1);
    check("clean_release_level",    32'(bus.level), 32'd0);
    step(20);

    // Glitch rejection on channel 1
    clear_counts();
    bus.btn_in = 2'b10;
    step(6);
    bus.btn_in = 2'b00;
    step(30);
    check("glitch_level",    32'(bus.level[1]), 32'd0);
    check("glitch_pressed",  32'(press_cnt[1]), 32'd0);
    check("glitch_released", 32'(rel_cnt[1]),   32'd0);

    // Simultaneous press and release of both channels
    clear_counts();
    bus.btn_in = 2'b11;
    wait_pulse(SEL_PRESS, 0, 20, cyc);
    check("simul_pressed", 32'(bus.pressed), 32'b11);
    check("simul_level_hi", 32'(bus.level),  32'b11);
    step(10);
    bus.btn_in = 2'b00;
    wait_pulse(SEL_RELEASE, 0, 20, cyc);
    check("simul_released", 32'(bus.released), 32'b11);
    check("simul_level_lo", 32'(bus.level),    32'd0);
    step(20);

    // Long press on channel 0
    clear_counts();
    bus.btn_in = 2'b01;
    wait_pulse(SEL_PRESS, 0, 20, cyc);
    check("long_press_initial", 32'(cyc > 0), 32'd1);
    wait_pulse(SEL_LONG, 0, 30, cyc);
    check("long_press_delay", 32'(cyc), 32'(HOLD_TICKS * TICK_DIV));
    check("long_press_bits",  32'(bus.long_press), 32'b01);
`ifdef MULTI_BUTTON_AUTOREPEAT_EN
    wait_pulse(SEL_PRESS, 0, 12, cyc);
    check("repeat_first_gap",  32'(cyc), 32'(REPEAT_TICKS * TICK_DIV));
    wait_pulse(SEL_PRESS, 0, 12, cyc);
    check("repeat_second_gap", 32'(cyc), 32'(REPEAT_TICKS * TICK_DIV));
    clear_counts();
    step(40);
    check("repeat_count_40",   32'(press_cnt[0]), 32'd5);
`else
    clear_counts();
    step(40);
    check("no_repeat_press",   32'(press_cnt[0]), 32'd0);
`endif
    check("long_press_once",   32'(long_cnt[0]), 32'd0);
    check("long_hold_level",   32'(bus.level),   32'b01);
    bus.btn_in = 2'b00;
    wait_pulse(SEL_RELEASE, 0, 20, cyc);
    check("long_release_seen", 32'(cyc > 0), 32'd1);
    step(20);

    // Mid-press reset with the button still held
    clear_counts();
    bus.btn_in = 2'b01;
    wait_pulse(SEL_PRESS, 0, 20, cyc);
    step(2);
    check("midrst_level_before", 32'(bus.level), 32'b01);
    rst = 1'b1;
    step(1);
    check("midrst_outputs_zero",
          32'({bus.level, bus.pressed, bus.released, bus.long_press}), 32'd0);
    rst = 1'b0;
    wait_pulse(SEL_PRESS, 0, 20, cyc);
    check("midrst_repress_latency", 32'(cyc), 32'd12);
    check("midrst_no_release",      32'(rel_cnt[0]), 32'd0);
    bus.btn_in = 2'b00;
    wait_pulse(SEL_RELEASE, 0, 20, cyc);
    step(20);

    // Bounce train: toggle every 3 cycles for 30 cycles, then stay high
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      bus.btn_in[0] = ((k % 2) == 0);
      step(3);
    end
    bus.btn_in[0] = 1'b1;
    check("bounce_no_early_press", 32'(press_cnt[0]), 32'd0);
    step(30);
    check("bounce_single_press",   32'(press_cnt[0]), 32'd1);
    check("bounce_level",          32'(bus.level),    32'b01);
    bus.btn_in = 2'b00;
    step(20);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_multi_button_detector

// File: doc/multi_button_detector.md
Name: multi_button_detector

Overview:
- N-channel successor to the single-button detector: 2-flop synchroniser, counter-based debounce, press/release edge pulses and long-press detection per channel.
- Runs entirely on the system clock; debounce sampling is paced by an internal tick enable, not a divided clock.
- All output pulses are exactly one system-clock cycle wide, so they feed FSMs such as the multiplier control directly.

Parameters:
- N_BTN, 5, number of independent button channels.
- TICK_DIV, 100000, system cycles per debounce sample tick (1 kHz at 100 MHz); legal range ≥ 2.
- DEB_SAMPLES, 4, consecutive ticks a new level must persist before it is accepted; legal range ≥ 1.
- HOLD_TICKS, 1000, ticks of continuous debounced-high before long_press fires; legal range ≥ 1.
- REPEAT_TICKS, 100, ticks between repeat pulses; used only with AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- btn_in  input  N_BTN  raw asynchronous button levels, active-high.
- level  output  N_BTN  debounced button state.
- pressed  output  N_BTN  1-cycle pulse on each accepted 0→1 of level (and on repeats, if enabled).
- released  output  N_BTN  1-cycle pulse on each accepted 1→0 of level.
- long_press  output  N_BTN  1-cycle pulse when a hold reaches HOLD_TICKS.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchronisers, tick counter, all per-channel counters, level, pressed, released and long_press all go to 0.
  - Reset during a press: level drops to 0 with no released pulse.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - tick is high for exactly one cycle when tick_cnt == TICK_DIV-1.
  - One generator is shared by all channels.
- Synchroniser:
  - Per channel, 2 flops on clk.
  - sync = btn_in delayed 2 cycles.
- Debounce, per channel, evaluated only on tick cycles:
  - If sync == level, deb_cnt ← 0.
  - If sync != level and deb_cnt < DEB_SAMPLES-1, deb_cnt ← deb_cnt+1.
  - If sync != level and deb_cnt == DEB_SAMPLES-1, level ← sync and deb_cnt ← 0.
  - A glitch shorter than DEB_SAMPLES consecutive ticks never changes level.
  - With DEB_SAMPLES=1, level follows sync at the first tick.
- Edge outputs, registered:
  - pressed is asserted in the same cycle level becomes 1; released in the same cycle level becomes 0.
  - Both deassert on the next cycle.
- Latency from a stable btn_in change to the level/pulse update:
  - 2 sync cycles plus DEB_SAMPLES ticks.
  - Bounds: ≥ 2+(DEB_SAMPLES-1)·TICK_DIV+1 and ≤ 2+DEB_SAMPLES·TICK_DIV cycles.
- Hold counter, per channel:
  - Cleared whenever level=0.
  - While level=1, increments on each tick, saturating at HOLD_TICKS.
  - long_press pulses for one cycle on the tick where hold_cnt goes HOLD_TICKS-1 → HOLD_TICKS.
  - Fires at most once per press.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses on the corresponding bits.
- Widths: counters are $clog2(param+1) bits; no overflow is possible.

Optional Feature:
- Macro: MULTI_BUTTON_AUTOREPEAT_EN.
- When defined:
  - After long_press fires, a rep_cnt counts ticks while level=1.
  - Every REPEAT_TICKS ticks it pulses pressed for one cycle, then rep_cnt ← 0.
  - Repeats continue until level=0; rep_cnt clears on level=0 or rst.
  - released still fires once, on the release.
- When undefined: no rep_cnt logic exists, and pressed pulses exactly once per debounced press.

Test Plan (bench parameters: N_BTN=2, TICK_DIV=4, DEB_SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2):
- Clean press: btn_in[0] 0→1 held 40 cycles →
  - level[0]=1 and pressed[0] is a 1-cycle pulse, within 11–14 cycles of the change.
  - released[0]=0 and channel 1 stays idle.
- Glitch rejection: btn_in[1] high for 6 cycles, then low → level[1] stays 0; no pressed or released pulse.
- Release plus simultaneity:
  - Both buttons pressed on the same cycle → pressed=2'b11 on the same cycle.
  - Both released on the same cycle → released=2'b11 on the same cycle, level=0.
- Long press: hold btn_in[0] high →
  - long_press[0] pulses once, 5 ticks after level[0] rose.
  - No second pulse over a further 40 cycles.
  - With MULTI_BUTTON_AUTOREPEAT_EN: pressed[0] pulses every 8 cycles after long_press.
- Mid-press reset: level[0]=1, assert rst for 1 cycle →
  - All outputs 0 on the next cycle, with no released pulse.
  - With the button still held, a new pressed pulse follows after the normal latency.
- Bounce train: btn_in[0] toggles every 3 cycles for 30 cycles, then stays high → exactly one pressed pulse, after the input settles.
